// File: rtl/verifuck_stdin_if.sv
// Byte stream from the UART receiver FIFO to the CPU's ',' instruction.
//   stdin       : byte at FIFO head
//   stdin_valid : FIFO non-empty
//   stdin_ready : consumer takes the head byte when both are high
// master = receiver side, slave = CPU side.
interface verifuck_stdin_if;
  logic [7:0] stdin;
  logic       stdin_valid;
  logic       stdin_ready;

  modport master (output stdin, output stdin_valid, input stdin_ready);
  modport slave  (input stdin, input stdin_valid, output stdin_ready);
endinterface

// File: rtl/verifuck_stdin.sv
// UART (8N1) receiver feeding a small byte FIFO that serves the CPU's
// stdin stream.
//   clk, rst_n  : clock, asynchronous active-low reset
//   uart_rx_pin : raw serial line, idle high, LSB first
//   io          : stdin / stdin_valid / stdin_ready handshake (master)
//   frame_err   : sticky, a frame ended with stop bit = 0
//   overrun     : sticky, a good byte was dropped because the FIFO was full
//   err_clr     : synchronous clear of both sticky flags (a same-cycle set wins)
module verifuck_stdin #(
  parameter int UART_RX_BAUD = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_pin,
  verifuck_stdin_if.master  io,
  output logic              frame_err,
  output logic              overrun,
  input  logic              err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF = 16'(UART_RX_BAUD / 2 - 1);
  localparam logic [15:0] FULL = 16'(UART_RX_BAUD - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  // ---------------- synchronizer ----------------
  logic       s1, rx;
  logic [1:0] sync_ok;   // fills with 1s once the chain holds real line samples
  logic       armed;     // line has been seen high since reset

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      rx      <= 1'b1;
      sync_ok <= 2'b00;
      armed   <= 1'b0;
    end else begin
      s1      <= uart_rx_pin;
      rx      <= s1;
      sync_ok <= {sync_ok[0], 1'b1};
      if (sync_ok[1] && rx) armed <= 1'b1;
    end
  end

  // ---------------- receiver FSM ----------------
  state_t      state, state_n;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg, push_data;
  logic        push_pend;
  logic        ld_half, ld_full, dec, smp, idx_clr, push_set, ferr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A low line before it has been seen high since reset is the tail of an
  // aborted frame, so it is parked in WAIT_IDLE instead of starting.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (sync_ok[1] && !rx) state_n = armed ? START : WAIT_IDLE;
      START:     if (cnt == 16'd0) state_n = rx ? IDLE : DATA;
      DATA:      if (cnt == 16'd0 && idx == 3'd7) state_n = STOP;
      STOP:      if (cnt == 16'd0) state_n = rx ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    ld_half  = 1'b0;
    ld_full  = 1'b0;
    dec      = 1'b0;
    smp      = 1'b0;
    idx_clr  = 1'b0;
    push_set = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE:  ld_half = sync_ok[1] && !rx && armed;
      START: if (cnt == 16'd0) begin
               ld_full = !rx;
               idx_clr = !rx;
             end else dec = 1'b1;
      DATA:  if (cnt == 16'd0) begin
               smp     = 1'b1;
               ld_full = 1'b1;
             end else dec = 1'b1;
      STOP:  if (cnt == 16'd0) begin
               push_set = rx;
               ferr_set = !rx;
             end else dec = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      push_pend <= 1'b0;
      push_data <= '0;
    end else begin
      if (ld_half)      cnt <= HALF;
      else if (ld_full) cnt <= FULL;
      else if (dec)     cnt <= cnt - 16'd1;
      if (idx_clr)  idx <= '0;
      else if (smp) idx <= idx + 3'd1;
      if (smp) shreg[idx] <= rx;
      // byte enters the FIFO one cycle after the stop-bit sample
      push_pend <= push_set;
      if (push_set) push_data <= shreg;
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, empty, pop, push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && io.stdin_ready;
  // a pop in the same cycle frees the slot the push needs
  assign push  = push_pend && (!full || pop);

  assign io.stdin       = mem[rptr[AW-1:0]];
  assign io.stdin_valid = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + PTR_ONE;
      end
      if (pop) rptr <= rptr + PTR_ONE;
    end
  end

  // ---------------- sticky errors ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (push_pend && !push) overrun <= 1'b1;
      else if (err_clr)       overrun <= 1'b0;
    end
  end
endmodule
